// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-client memory arbiter
// State encoding, client ids and default port widths used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic CLI_I = 1'b0;
  localparam logic CLI_D = 1'b1;

  function automatic arb_state_e grant_state(input logic id);
    return (id == CLI_D) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational grant selection between the I and D clients
// ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise D has fixed priority over I.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic rr_last,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, serve whichever client was not granted last.
  always_comb begin
    grant_id = CLI_I;
    if (i_req && d_req) begin
      grant_id = (rr_last == CLI_D) ? CLI_I : CLI_D;
    end else if (d_req) begin
      grant_id = CLI_D;
    end
  end
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
  assign grant_id       = d_req ? CLI_D : CLI_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - grants the shared main-memory port to the I-cache or D-cache
// Grant held until mem_ready or client abort; tie policy set by ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic       i_req, d_req;
  logic       grant_valid, grant_id;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .rr_last     (rr_last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= CLI_I;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Every grant returns through IDLE, so a client holding its request is re-arbitrated.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d   = grant_state(grant_id);
          rr_last_d = grant_id;
        end
      end
      GNT_I: begin
        if (mem_ready || !i_req) state_d = IDLE;
      end
      GNT_D: begin
        if (mem_ready || !d_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write wins when a client raises both strobes.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    i_rdata   = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    case (state_q)
      GNT_I: begin
        mem_write = i_write;
        mem_read  = i_read & ~i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ready   = mem_ready;
        i_rdata   = mem_ready ? mem_rdata : '0;
      end
      GNT_D: begin
        mem_write = d_write;
        mem_read  = d_read & ~d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
        d_rdata   = mem_ready ? mem_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule
